// File: rtl/al_pcie_pkg.sv
// Shared definitions for the RAM-to-PCIe MemWr engine: page size, MPS decode, FSM states.
package al_pcie_pkg;
  localparam int         PAGE_BYTES   = 4096;
  localparam logic [2:0] MPS_CODE_MAX = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_ISSUE} wr_state_e;

  // Illegal codes 6/7 are clamped to 4 KB rather than overflowing the shift.
  function automatic logic [12:0] mps_bytes(input logic [2:0] code);
    logic [2:0] c;
    c = (code > MPS_CODE_MAX) ? MPS_CODE_MAX : code;
    return 13'd128 << c;
  endfunction
endpackage

// File: rtl/al_burst_size_calc.sv
// Combinational burst size: min of remaining beats, MPS, distance to the 4 KB page end and the length field limit.
module al_burst_size_calc
  import al_pcie_pkg::*;
#(
  parameter int DATA_BITS        = 4,
  parameter int REQUEST_LEN_BITS = 6,
  parameter int DESC_LEN_BITS    = 16
) (
  input  logic [DESC_LEN_BITS:0]    remaining,
  input  logic [2:0]                cfg_max_payload,
  input  logic [11-DATA_BITS:0]     page_off,
  output logic [REQUEST_LEN_BITS:0] burst
);
  localparam int W_RM  = DESC_LEN_BITS + 1;
  localparam int W_MX  = REQUEST_LEN_BITS + 1;
  localparam int W_A   = (W_RM > 13) ? W_RM : 13;
  localparam int CW    = ((W_A > W_MX) ? W_A : W_MX) + 1;

  logic [CW-1:0] rem_w, mps_w, bnd_w, max_w, m01, m23, m_all;

  always_comb begin
    rem_w = CW'(remaining);
    mps_w = CW'(mps_bytes(cfg_max_payload)) >> DATA_BITS;
    if (mps_w == '0) mps_w = CW'(1);
    // page_off is beat-aligned, so this is never 0 beats; a zero offset yields a full page
    bnd_w = (CW'(PAGE_BYTES) - (CW'(page_off) << DATA_BITS)) >> DATA_BITS;
    max_w = CW'(1) << REQUEST_LEN_BITS;
    m01   = (rem_w < mps_w) ? rem_w : mps_w;
    m23   = (bnd_w < max_w) ? bnd_w : max_w;
    m_all = (m01 < m23) ? m01 : m23;
    burst = m_all[REQUEST_LEN_BITS:0];
  end
endmodule

// File: rtl/al_pcie_memwr_splitter.sv
// Splits one DMA write descriptor into TLP-sized tcq bursts, tracks in-order completions, reports done.
module al_pcie_memwr_splitter
  import al_pcie_pkg::*;
#(
  parameter int LOCAL_ADDR_WIDTH  = 17,
  parameter int REMOTE_ADDR_WIDTH = 32,
  parameter int DATA_BITS         = 4,
  parameter int REQUEST_LEN_BITS  = 6,
  parameter int MEM_TAG           = 1,
  parameter int DESC_LEN_BITS     = 16,
  parameter int DESC_ID_BITS      = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    s_desc_valid,
  output logic                                    s_desc_ready,
  input  logic [LOCAL_ADDR_WIDTH-DATA_BITS-1:0]   s_desc_laddr,
  input  logic [REMOTE_ADDR_WIDTH-DATA_BITS-1:0]  s_desc_raddr,
  input  logic [DESC_LEN_BITS-1:0]                s_desc_len,
  input  logic [DESC_ID_BITS-1:0]                 s_desc_id,
  input  logic [2:0]                              cfg_max_payload,
  output logic                                    m_tcq_valid,
  input  logic                                    m_tcq_ready,
  output logic [LOCAL_ADDR_WIDTH-DATA_BITS-1:0]   m_tcq_laddr,
  output logic [REMOTE_ADDR_WIDTH-DATA_BITS-1:0]  m_tcq_raddr,
  output logic [REQUEST_LEN_BITS-1:0]             m_tcq_length,
  output logic [MEM_TAG-1:0]                      m_tcq_tag,
  input  logic                                    m_tcq_cvalid,
  output logic                                    m_tcq_cready,
  input  logic [MEM_TAG-1:0]                      m_tcq_ctag,
  output logic                                    m_done_valid,
  input  logic                                    m_done_ready,
  output logic [DESC_ID_BITS-1:0]                 m_done_id,
  output logic                                    err_tag
);
  localparam int LW = LOCAL_ADDR_WIDTH - DATA_BITS;
  localparam int RW = REMOTE_ADDR_WIDTH - DATA_BITS;
  localparam int NT = 2 ** MEM_TAG;

  typedef struct packed {
    logic [LW-1:0]               laddr;
    logic [RW-1:0]               raddr;
    logic [REQUEST_LEN_BITS-1:0] length;
    logic [MEM_TAG-1:0]          tag;
  } tcq_req_t;

  wr_state_e state, state_nx;
  tcq_req_t  req;

  logic [DESC_LEN_BITS:0]    rem_q;
  logic [DESC_ID_BITS-1:0]   id_q;
  logic [REQUEST_LEN_BITS:0] burst_q, burst_c, burst_m1;
  logic [MEM_TAG-1:0]        exp_tag;
  logic [MEM_TAG:0]          outst;
  logic [NT-1:0]             tbl_last;
  logic [DESC_ID_BITS-1:0]   tbl_id [NT];
  logic [DESC_ID_BITS-1:0]   dq_id [2];
  logic                      dq_wr, dq_rd;
  logic [1:0]                dq_cnt;

  logic desc_hs, tbl_free, issue_hs, last_burst, cpl, cpl_dec;
  logic done_push, done_pop, done_ok;

  assign s_desc_ready = (state == ST_IDLE) && !rst;
  assign desc_hs      = s_desc_valid && s_desc_ready;
  assign tbl_free     = outst < (MEM_TAG+1)'(NT);
  assign m_tcq_valid  = (state == ST_ISSUE) && tbl_free;
  assign issue_hs     = m_tcq_valid && m_tcq_ready;
  assign last_burst   = rem_q == (DESC_LEN_BITS+1)'(burst_q);
  assign m_tcq_cready = !rst;
  assign cpl          = m_tcq_cvalid && m_tcq_cready;
  assign cpl_dec      = cpl && (outst != '0);
  assign done_push    = cpl && tbl_last[m_tcq_ctag];
  assign done_pop     = m_done_valid && m_done_ready;
  assign done_ok      = (dq_cnt != 2'd2) || done_pop;
  assign burst_m1     = burst_c - 1'b1;

  assign m_tcq_laddr  = req.laddr;
  assign m_tcq_raddr  = req.raddr;
  assign m_tcq_length = req.length;
  assign m_tcq_tag    = req.tag;
  assign m_done_valid = dq_cnt != 2'd0;
  assign m_done_id    = dq_id[dq_rd];

  al_burst_size_calc #(
    .DATA_BITS        (DATA_BITS),
    .REQUEST_LEN_BITS (REQUEST_LEN_BITS),
    .DESC_LEN_BITS    (DESC_LEN_BITS)
  ) u_bsz (
    .remaining       (rem_q),
    .cfg_max_payload (cfg_max_payload),
    .page_off        (req.raddr[11-DATA_BITS:0]),
    .burst           (burst_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (desc_hs) state_nx = ST_CALC;
      ST_CALC:  state_nx = ST_ISSUE;
      ST_ISSUE: if (issue_hs) state_nx = last_burst ? ST_IDLE : ST_CALC;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req      <= '0;
      rem_q    <= '0;
      id_q     <= '0;
      burst_q  <= '0;
      exp_tag  <= '0;
      outst    <= '0;
      tbl_last <= '0;
      for (int i = 0; i < NT; i++) tbl_id[i] <= '0;
      dq_id[0] <= '0;
      dq_id[1] <= '0;
      dq_wr    <= 1'b0;
      dq_rd    <= 1'b0;
      dq_cnt   <= 2'd0;
      err_tag  <= 1'b0;
    end else begin
      if (desc_hs) begin
        req.laddr <= s_desc_laddr;
        req.raddr <= s_desc_raddr;
        rem_q     <= {1'b0, s_desc_len} + 1'b1;
        id_q      <= s_desc_id;
      end
      if (state == ST_CALC) begin
        burst_q    <= burst_c;
        req.length <= burst_m1[REQUEST_LEN_BITS-1:0];
      end
      if (issue_hs) begin
        req.laddr        <= req.laddr + LW'(burst_q);
        req.raddr        <= req.raddr + RW'(burst_q);
        rem_q            <= rem_q - (DESC_LEN_BITS+1)'(burst_q);
        tbl_last[req.tag] <= last_burst;
        tbl_id[req.tag]  <= id_q;
        req.tag          <= req.tag + 1'b1;
      end
      if (issue_hs && !cpl_dec)      outst <= outst + 1'b1;
      else if (!issue_hs && cpl_dec) outst <= outst - 1'b1;
      // the entry is consumed even on a tag mismatch so the rolling counter stays aligned
      if (cpl) begin
        exp_tag <= exp_tag + 1'b1;
        if (m_tcq_ctag != exp_tag) err_tag <= 1'b1;
      end
      if (done_push && !done_ok) err_tag <= 1'b1;
      if (done_push && done_ok) begin
        dq_id[dq_wr] <= tbl_id[m_tcq_ctag];
        dq_wr        <= ~dq_wr;
      end
      if (done_pop) dq_rd <= ~dq_rd;
      case ({done_push && done_ok, done_pop})
        2'b10:   dq_cnt <= dq_cnt + 2'd1;
        2'b01:   dq_cnt <= dq_cnt - 2'd1;
        default: dq_cnt <= dq_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_al_pcie_memwr_splitter.sv
// Randomized bench for al_pcie_memwr_splitter against a burst-list/queue reference model.
module tb_al_pcie_memwr_splitter;
  localparam int LW = 13;
  localparam int RW = 28;
  localparam int NT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_desc_valid, s_desc_ready;
  logic [LW-1:0] s_desc_laddr;
  logic [RW-1:0] s_desc_raddr;
  logic [15:0]   s_desc_len;
  logic [3:0]    s_desc_id;
  logic [2:0]    cfg_max_payload;
  logic          m_tcq_valid, m_tcq_ready;
  logic [LW-1:0] m_tcq_laddr;
  logic [RW-1:0] m_tcq_raddr;
  logic [5:0]    m_tcq_length;
  logic [0:0]    m_tcq_tag;
  logic          m_tcq_cvalid, m_tcq_cready;
  logic [0:0]    m_tcq_ctag;
  logic          m_done_valid, m_done_ready;
  logic [3:0]    m_done_id;
  logic          err_tag;

  al_pcie_memwr_splitter #(
    .LOCAL_ADDR_WIDTH(17), .REMOTE_ADDR_WIDTH(32), .DATA_BITS(4), .REQUEST_LEN_BITS(6),
    .MEM_TAG(1), .DESC_LEN_BITS(16), .DESC_ID_BITS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
    .s_desc_laddr(s_desc_laddr), .s_desc_raddr(s_desc_raddr),
    .s_desc_len(s_desc_len), .s_desc_id(s_desc_id),
    .cfg_max_payload(cfg_max_payload),
    .m_tcq_valid(m_tcq_valid), .m_tcq_ready(m_tcq_ready),
    .m_tcq_laddr(m_tcq_laddr), .m_tcq_raddr(m_tcq_raddr),
    .m_tcq_length(m_tcq_length), .m_tcq_tag(m_tcq_tag),
    .m_tcq_cvalid(m_tcq_cvalid), .m_tcq_cready(m_tcq_cready), .m_tcq_ctag(m_tcq_ctag),
    .m_done_valid(m_done_valid), .m_done_ready(m_done_ready), .m_done_id(m_done_id),
    .err_tag(err_tag)
  );

  always #5 clk = ~clk;

  typedef struct {int laddr; longint raddr; int len; bit last; int id;} burst_t;
  typedef struct {int tag; bit last; int id;} cpl_t;

  burst_t expq[$];
  burst_t pinq[$];
  cpl_t   outq[$];
  int     exp_done[$];

  int n_vec = 0, n_err = 0;
  int mtag = 0, mout = 0, issue_cnt = 0, done_cnt = 0, last_tag = 0;
  bit exp_err = 1'b0;
  bit hold = 1'b0, stall_tcq = 1'b0;
  int allow = 0, used = 0, corr_req = 0, corr_used = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: each burst is the largest chunk that fits remaining, MPS, page end and 64 beats.
  task automatic gen(input int la, input longint ra, input int len, input int code, input int id);
    int rem, b, mps, bnd;
    burst_t e;
    rem = len + 1;
    while (rem > 0) begin
      mps = (128 << code) / 16;
      if (mps < 1) mps = 1;
      bnd = (4096 - int'((ra * 16) % 4096)) / 16;
      b = rem;
      if (mps < b) b = mps;
      if (bnd < b) b = bnd;
      if (64 < b) b = 64;
      e.laddr = la % 8192; e.raddr = ra % (64'd1 << 28); e.len = b - 1;
      e.last = (rem == b); e.id = id;
      expq.push_back(e);
      pinq.push_back(e);
      la = (la + b) % 8192; ra = ra + b; rem = rem - b;
    end
  endtask

  task automatic send_desc(input int la, input longint ra, input int len, input int code, input int id);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (s_desc_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL desc_accept_timeout: ready=%0d, required 1", s_desc_ready);
      return;
    end
    gen(la, ra, len, code, id);
    cfg_max_payload = 3'(code);
    s_desc_laddr = LW'(la); s_desc_raddr = RW'(ra);
    s_desc_len = 16'(len); s_desc_id = 4'(id);
    s_desc_valid = 1'b1;
    @(posedge clk); #1;
    s_desc_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && outq.size() == 0 && exp_done.size() == 0 && !m_done_valid) begin
        ok = 1'b1; break;
      end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: pending bursts %0d cpl %0d done %0d, required 0",
               expq.size(), outq.size(), exp_done.size());
    end
  endtask

  task automatic check_idle(input string pfx);
    chk({pfx, "_desc_ready"}, s_desc_ready, 0);
    chk({pfx, "_tcq_valid"},  m_tcq_valid, 0);
    chk({pfx, "_tcq_laddr"},  m_tcq_laddr, 0);
    chk({pfx, "_tcq_raddr"},  m_tcq_raddr, 0);
    chk({pfx, "_tcq_length"}, m_tcq_length, 0);
    chk({pfx, "_tcq_tag"},    m_tcq_tag, 0);
    chk({pfx, "_cready"},     m_tcq_cready, 0);
    chk({pfx, "_done_valid"}, m_done_valid, 0);
    chk({pfx, "_done_id"},    m_done_id, 0);
    chk({pfx, "_err_tag"},    err_tag, 0);
  endtask

  // tcq/done ready: done_ready drops at most one cycle in four so the done FIFO cannot overflow
  initial begin
    int k;
    k = 0;
    m_tcq_ready = 1'b0; m_done_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      k++;
      m_tcq_ready  = !stall_tcq && ($urandom % 4 != 0);
      m_done_ready = !((k % 4 == 0) && ($urandom % 2 == 0));
    end
  end

  // completion responder, strictly in issue order
  initial begin
    m_tcq_cvalid = 1'b0; m_tcq_ctag = '0;
    forever begin
      @(posedge clk); #1;
      m_tcq_cvalid = 1'b0;
      if (!rst && outq.size() > 0) begin
        if (hold ? (used < allow) : ($urandom % 3 == 0)) begin
          m_tcq_cvalid = 1'b1;
          m_tcq_ctag   = 1'(outq[0].tag);
          if (corr_used < corr_req) begin
            m_tcq_ctag = ~m_tcq_ctag;
            corr_used++;
          end
          if (hold) used++;
        end
      end
    end
  end

  // compare process: every cycle outside reset
  initial begin
    burst_t e;
    cpl_t   c;
    bit     inc;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete(); outq.delete(); exp_done.delete();
        mtag = 0; mout = 0; exp_err = 1'b0;
      end else begin
        inc = 1'b0;
        chk("cready", m_tcq_cready, 1);
        chk("err_tag", err_tag, exp_err);
        if (mout >= NT) chk("valid_when_full", m_tcq_valid, 0);
        if (m_tcq_valid && m_tcq_ready) begin
          if (expq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_burst: raddr 0x%0h issued, none required", m_tcq_raddr);
          end else begin
            e = expq.pop_front();
            chk("tcq_laddr", m_tcq_laddr, e.laddr);
            chk("tcq_raddr", m_tcq_raddr, e.raddr);
            chk("tcq_length", m_tcq_length, e.len);
            chk("tcq_tag", m_tcq_tag, mtag);
            c.tag = mtag; c.last = e.last; c.id = e.id;
            outq.push_back(c);
          end
          issue_cnt++;
          last_tag = int'(m_tcq_tag);
          mtag = (mtag + 1) % NT;
          inc = 1'b1;
        end
        if (m_tcq_cvalid && outq.size() > 0) begin
          c = outq.pop_front();
          if (int'(m_tcq_ctag) != c.tag) exp_err = 1'b1;
          if (c.last) exp_done.push_back(c.id);
          if (mout > 0) mout--;
        end
        if (inc) mout++;
        if (m_done_valid && m_done_ready) begin
          if (exp_done.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL spurious_done: id %0d, none required", m_done_id);
          end else chk("done_id", m_done_id, exp_done.pop_front());
          done_cnt++;
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, i0;
    bit ok;
    s_desc_valid = 1'b0; s_desc_laddr = '0; s_desc_raddr = '0;
    s_desc_len = '0; s_desc_id = '0; cfg_max_payload = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("rst");
    @(posedge clk); #1 rst = 1'b0;

    // 32 beats at 8-beat MPS from 0x1000
    pinq.delete(); d0 = done_cnt;
    send_desc('h010, 'h100, 31, 0, 5);
    chk("t1_nbursts", pinq.size(), 4);
    for (int i = 0; i < pinq.size() && i < 4; i++) begin
      chk("t1_raddr", pinq[i].raddr, 'h100 + 8 * i);
      chk("t1_len", pinq[i].len, 7);
    end
    wait_drain();
    chk("t1_done_cnt", done_cnt - d0, 1);

    // 0xFE0 byte start: 2 beats to the page end, then 8
    pinq.delete();
    send_desc('h020, 'h0FE, 9, 1, 6);
    chk("t2_nbursts", pinq.size(), 2);
    if (pinq.size() == 2) begin
      chk("t2_len0", pinq[0].len, 1);
      chk("t2_len1", pinq[1].len, 7);
      chk("t2_raddr1", pinq[1].raddr, 'h100);
    end
    wait_drain();

    // completions withheld: only two bursts in flight
    i0 = issue_cnt; allow = used; hold = 1'b1;
    send_desc('h040, 'h300, 23, 0, 7);
    repeat (30) @(negedge clk);
    chk("t3_issued2", issue_cnt - i0, 2);
    chk("t3_stalled", m_tcq_valid, 0);
    allow = used + 1;
    repeat (20) @(negedge clk);
    chk("t3_issued3", issue_cnt - i0, 3);
    chk("t3_tag3", last_tag, 0);
    hold = 1'b0;
    wait_drain();

    // wrong ctag on a non-last burst
    i0 = issue_cnt; allow = used; hold = 1'b1;
    send_desc('h080, 'h400, 23, 0, 8);
    repeat (30) @(negedge clk);
    chk("t4_issued2", issue_cnt - i0, 2);
    corr_req = corr_req + 1; allow = used + 1;
    repeat (10) @(negedge clk);
    chk("t4_err", err_tag, 1);
    hold = 1'b0;
    wait_drain();
    chk("t4_err_sticky", err_tag, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t4_err_cleared", err_tag, 0);

    // local address wrap at the top of RAM
    pinq.delete();
    send_desc('h1FF8, 'h200, 15, 0, 9);
    chk("t5_nbursts", pinq.size(), 2);
    if (pinq.size() == 2) begin
      chk("t5_laddr0", pinq[0].laddr, 'h1FF8);
      chk("t5_laddr1", pinq[1].laddr, 'h0000);
      chk("t5_raddr1", pinq[1].raddr, 'h208);
    end
    wait_drain();

    repeat (40)
      send_desc($urandom % 8192, longint'($urandom % (1 << 20)), $urandom_range(0, 150),
                $urandom_range(0, 5), $urandom % 16);
    wait_drain();

    // reset while a request is pending
    stall_tcq = 1'b1;
    send_desc('h010, 'h100, 31, 0, 3);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_tcq_valid) begin ok = 1'b1; break; end
    end
    chk("t6_valid_seen", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("t6");
    @(posedge clk); #1 rst = 1'b0;
    stall_tcq = 1'b0;
    d0 = done_cnt;
    send_desc('h010, 'h100, 31, 0, 5);
    wait_drain();
    chk("t6_done_cnt", done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
